// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant is held for a whole packet (or MAX_BURST beats) so packets never interleave.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_din,
    input  logic                       fifo_full,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] last_grant, last_grant_nxt;
    logic [GW-1:0] grant_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          found;
    logic [GW-1:0] pick;
    int            idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            busy       <= (state_nxt == GRANT);
        end
    end

    // Next state plus the combinational data path through to the FIFO.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        req_ready      = '0;
        fifo_wr_en     = 1'b0;
        fifo_din       = '0;
        found          = 1'b0;
        pick           = '0;
        idx            = 0;

        case (state)
            IDLE: begin
                // Scan from the producer after the last grantee.
                for (int k = 1; k <= int'(NUM_REQ); k++) begin
                    idx = (int'(last_grant) + k) % int'(NUM_REQ);
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        pick  = GW'(idx);
                    end
                end
                if (found) begin
                    grant_nxt    = pick;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = !fifo_full;
                fifo_wr_en          = req_valid[grant_id] && !fifo_full;
                if (fifo_wr_en) begin
                    fifo_din     = req_data[int'(grant_id)*WIDTH +: WIDTH];
                    beat_cnt_nxt = beat_cnt + CW'(1);
                    if (req_last[grant_id] || beat_cnt == CW'(MAX_BURST - 1)) begin
                        last_grant_nxt = grant_id;
                        beat_cnt_nxt   = '0;
                        state_nxt      = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Nothing may be accepted or written in a reset cycle.
        if (rst) begin
            req_ready  = '0;
            fifo_wr_en = 1'b0;
            fifo_din   = '0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed packet scenarios plus random traffic,
// checked every cycle against a packet-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_din;
    logic           fifo_full;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Producer packet queues: bit 8 = last flag, bits 7:0 = data.
    logic [8:0]   pq [N][$];
    logic [N-1:0] hold;

    // Reference model: owner of the write port (-1 = nobody), beats in this grant.
    int m_owner, m_gid, m_cnt, m_last;

    typedef struct { int p; logic [7:0] d; int c; } wr_t;
    wr_t wlog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [8:0]   e;
        logic [N-1:0] exp_ready, hs;
        logic         exp_wr;
        logic [W-1:0] exp_din;
        int           pick;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && !hold[i]) begin
                e = pq[i][0];
                req_valid[i]      = 1'b1;
                req_data[i*W +: W] = e[7:0];
                req_last[i]       = e[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*W +: W] = W'($urandom);
                req_last[i]       = 1'($urandom);
            end
        end
        #1;
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_din   = '0;
        if (!rst && m_owner >= 0) begin
            exp_ready[m_owner] = !fifo_full;
            exp_wr = req_valid[m_owner] && !fifo_full;
            if (exp_wr) exp_din = req_data[m_owner*W +: W];
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        chk("fifo_din", 32'(fifo_din), 32'(exp_din));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        if (fifo_full && fifo_wr_en) chk("wr_while_full", 32'(fifo_wr_en), 32'(0));
        if (fifo_wr_en) wlog.push_back('{int'(grant_id), fifo_din, cyc});
        hs = req_ready & req_valid;
        // Advance the model across the coming clock edge.
        if (rst) begin
            m_owner = -1; m_gid = 0; m_cnt = 0; m_last = N - 1;
        end else if (m_owner < 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
            if (pick >= 0) begin
                m_owner = pick; m_gid = pick; m_cnt = 0;
            end
        end else if (exp_wr) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_last = m_owner; m_owner = -1; m_cnt = 0;
            end
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++)
            if (hs[i] && !rst) void'(pq[i].pop_front());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pq[i].delete();
        hold = '0; fifo_full = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wlog.delete();
    endtask

    initial begin
        logic [8:0] e;
        int p, len;
        rst = 1'b1; fifo_full = 1'b0; hold = '0;
        req_valid = '0; req_data = '0; req_last = '0;
        m_owner = -1; m_gid = 0; m_cnt = 0; m_last = N - 1;
        @(negedge clk); @(negedge clk);

        // Reset values
        do_reset();
        run(2);

        // 1: alternating single-beat packets from producers 0 and 2
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pq[0].push_back({1'b1, 8'(8'h10 + k)});
            pq[2].push_back({1'b1, 8'(8'h20 + k)});
        end
        run(18);
        chk("t1_count", 32'(wlog.size()), 32'd8);
        for (int k = 0; k < 8 && k < wlog.size(); k++) begin
            chk("t1_prod", 32'(wlog[k].p), 32'((k % 2) * 2));
            chk("t1_data", 32'(wlog[k].d), 32'(((k % 2) ? 8'h20 : 8'h10) + k / 2));
            if (k > 0) chk("t1_gap", 32'(wlog[k].c - wlog[k-1].c), 32'd2);
        end

        // 2: 3-beat packet from producer 1 is not interleaved with producer 3
        do_reset();
        pq[1].push_back({1'b0, 8'hA1});
        pq[1].push_back({1'b0, 8'hA2});
        pq[1].push_back({1'b1, 8'hA3});
        pq[3].push_back({1'b1, 8'hB0});
        run(9);
        chk("t2_count", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            chk("t2_d0", 32'(wlog[0].d), 32'hA1);
            chk("t2_d1", 32'(wlog[1].d), 32'hA2);
            chk("t2_d2", 32'(wlog[2].d), 32'hA3);
            chk("t2_contig", 32'(wlog[2].c - wlog[0].c), 32'd2);
            chk("t2_p3", 32'(wlog[3].p), 32'd3);
            chk("t2_d3", 32'(wlog[3].d), 32'hB0);
        end

        // 3: 20 beats without last are split at MAX_BURST
        do_reset();
        for (int k = 0; k < 20; k++) pq[0].push_back({1'b0, 8'(k)});
        run(26);
        chk("t3_count", 32'(wlog.size()), 32'd20);
        for (int k = 0; k < 20 && k < wlog.size(); k++) begin
            chk("t3_prod", 32'(wlog[k].p), 32'd0);
            chk("t3_data", 32'(wlog[k].d), 32'(k));
        end
        if (wlog.size() == 20) chk("t3_release_gap", 32'(wlog[16].c - wlog[15].c), 32'd2);

        // 4: fifo_full for 5 cycles mid-packet
        do_reset();
        for (int k = 0; k < 6; k++) pq[2].push_back({1'(k == 5), 8'(8'h40 + k)});
        run(3);
        fifo_full = 1'b1;
        run(5);
        fifo_full = 1'b0;
        run(6);
        chk("t4_count", 32'(wlog.size()), 32'd6);
        for (int k = 0; k < 6 && k < wlog.size(); k++)
            chk("t4_data", 32'(wlog[k].d), 32'(8'h40 + k));
        if (wlog.size() == 6) chk("t4_stall_gap", 32'(wlog[2].c - wlog[1].c), 32'd6);

        // 5: grantee drops valid 3 cycles while others wait
        do_reset();
        for (int k = 0; k < 5; k++) pq[1].push_back({1'(k == 4), 8'(8'h50 + k)});
        run(3);
        pq[0].push_back({1'b1, 8'h60});
        pq[3].push_back({1'b1, 8'h61});
        hold = 4'b0010;
        run(3);
        hold = '0;
        run(10);
        chk("t5_count", 32'(wlog.size()), 32'd7);
        if (wlog.size() == 7) begin
            for (int k = 0; k < 5; k++) chk("t5_data", 32'(wlog[k].d), 32'(8'h50 + k));
            chk("t5_hold_gap", 32'(wlog[2].c - wlog[1].c), 32'd4);
            chk("t5_next_p3", 32'(wlog[5].p), 32'd3);
            chk("t5_then_p0", 32'(wlog[6].p), 32'd0);
        end

        // 6: reset during a GRANT beat
        do_reset();
        for (int k = 0; k < 10; k++) pq[2].push_back({1'b0, 8'(8'h70 + k)});
        run(3);
        pq[0].push_back({1'b1, 8'h77});
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wlog.delete();
        run(3);
        chk("t6_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            chk("t6_prod", 32'(wlog[0].p), 32'd0);
            chk("t6_data", 32'(wlog[0].d), 32'h77);
        end

        // Random traffic with backpressure and producer stalls
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                p   = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 20));
                if (pq[p].size() < 40)
                    for (int j = 0; j < len; j++) begin
                        e = {1'(j == len - 1), 8'($urandom)};
                        pq[p].push_back(e);
                    end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            cycle();
        end
        fifo_full = 1'b0;
        hold = '0;
        for (int t = 0; t < 3000; t++) begin
            if (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() == 0) break;
            cycle();
        end
        for (int i = 0; i < N; i++) chk("drain", 32'(pq[i].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
